// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes, datapath selects.
// No logic of its own; types and constants only.
// Backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_ANDI = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_BEQ  = 6'd7;
    localparam logic [5:0] OP_BNE  = 6'd8;
    localparam logic [5:0] OP_J    = 6'd9;
    localparam logic [5:0] OP_JAL  = 6'd10;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_PASS_A = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } wb_sel_e;

    // One-hot-ish instruction class plus the ALU operation the class needs in EXEC.
    typedef struct packed {
        logic    rtype;
        logic    itype;
        logic    load;
        logic    store;
        logic    branch;
        logic    bne;      // qualifies branch: 1 = BNE, 0 = BEQ
        logic    jump;
        logic    jal;
        logic    illegal;
        alu_op_e alu_op;
    } op_class_t;

    // BEQ takes on zero, BNE takes on non-zero.
    function automatic logic branch_taken(input op_class_t cls, input logic zero);
        return cls.branch & (cls.bne ? ~zero : zero);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode classifier: maps IR[31:26] to an instruction class and its EXEC-stage ALU op.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_cls
);

    // Classify the opcode; anything outside the defined table is illegal.
    always_comb begin
        o_cls        = '0;
        o_cls.alu_op = ALU_ADD;
        case (i_opcode)
            OP_ADD:  o_cls.rtype = 1'b1;
            OP_SUB:  begin o_cls.rtype = 1'b1; o_cls.alu_op = ALU_SUB; end
            OP_AND:  begin o_cls.rtype = 1'b1; o_cls.alu_op = ALU_AND; end
            OP_ADDI: o_cls.itype = 1'b1;
            OP_ANDI: begin o_cls.itype = 1'b1; o_cls.alu_op = ALU_AND; end
            OP_LW:   o_cls.load  = 1'b1;
            OP_SW:   o_cls.store = 1'b1;
            OP_BEQ:  begin o_cls.branch = 1'b1; o_cls.alu_op = ALU_SUB; end
            OP_BNE:  begin o_cls.branch = 1'b1; o_cls.bne = 1'b1; o_cls.alu_op = ALU_SUB; end
            OP_J:    o_cls.jump  = 1'b1;
            OP_JAL:  o_cls.jal   = 1'b1;
            default: o_cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with a retired-instruction counter.
// Latency: outputs combinational from state and inputs; state/counter update each core clock.
// Backpressure: FETCH and MEM hold, strobes asserted, until mem_ready; no timeout.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int RA_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst_sel,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    // The return-address index is applied by the register-file mux; it must name a real register.
    if (RA_REG < 0 || RA_REG > 31) begin : g_bad_ra_reg
        $error("RA_REG must index one of 32 registers");
    end

    state_e           r_state;
    state_e           w_next_state;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;
    op_class_t        w_cls;

    mc_ctrl_decode u_decode (
        .i_opcode (opcode),
        .o_cls    (w_cls)
    );

    assign state       = r_state;
    assign instr_count = r_count;

    // State register; reset parks the FSM in IDLE so every output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, bumped on the transition back into FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Next-state and control outputs; everything idles low unless the state asks for it.
    always_comb begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_SEQ;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        reg_dst_sel  = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        wb_sel       = WB_SEL_ALU;
        illegal_op   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = PC_SRC_SEQ;
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_DECODE: begin
                if (w_cls.jump) begin
                    pc_write     = 1'b1;
                    pc_src       = PC_SRC_JUMP;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_cls.jal) begin
                    w_next_state = ST_WB;
                end else if (w_cls.illegal) begin
                    // Dropped without retiring; the core simply fetches the next word.
                    illegal_op   = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (w_cls.branch) begin
                    alu_op    = ALU_SUB;
                    alu_src_b = 1'b0;
                    if (branch_taken(w_cls, zero)) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_BRANCH;
                    end
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_cls.rtype) begin
                    alu_op       = w_cls.alu_op;
                    alu_src_b    = 1'b0;
                    w_next_state = ST_WB;
                end else if (w_cls.itype) begin
                    alu_op       = w_cls.alu_op;
                    alu_src_b    = 1'b1;
                    w_next_state = ST_WB;
                end else if (w_cls.load || w_cls.store) begin
                    // Address = base + sign-extended offset.
                    alu_op       = w_cls.alu_op;
                    alu_src_b    = 1'b1;
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_MEM: begin
                if (w_cls.load) begin
                    mem_read     = 1'b1;
                    w_next_state = mem_ready ? ST_WB : ST_MEM;
                end else if (w_cls.store) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_MEM;
                    end
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_WB: begin
                reg_write    = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
                if (w_cls.jal) begin
                    // Link register gets PC+4 while the PC jumps in the same cycle.
                    wb_sel      = WB_SEL_PC;
                    reg_dst_sel = 1'b1;
                    pc_write    = 1'b1;
                    pc_src      = PC_SRC_JUMP;
                end else if (w_cls.load) begin
                    wb_sel = WB_SEL_MEM;
                end else begin
                    wb_sel = WB_SEL_ALU;
                end
            end

            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction-stream bench for mc_control_unit against a trace-generating model.
// Latency: checks every cycle at the falling edge.
// Backpressure: mem_ready wait cycles are randomized in FETCH and MEM.
module tb_mc_control_unit;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5;

    typedef struct packed {
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       rw;
        logic       rds;
        logic       asb;
        logic [2:0] aop;
        logic       mr;
        logic       mw;
        logic [1:0] wbs;
        logic [2:0] st;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        zr;
        outs_t       exp;
        logic [31:0] cnt;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        reg_write;
    logic        reg_dst_sel;
    logic        alu_src_b;
    logic [2:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        illegal_op;
    logic [31:0] instr_count;
    outs_t       obs;

    cyc_t        q[$];
    logic [31:0] m_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.CNT_W(32), .RA_REG(31)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst_sel (reg_dst_sel),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .wb_sel      (wb_sel),
        .state       (state),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    assign obs = {pc_write, pc_src, ir_write, reg_write, reg_dst_sel, alu_src_b,
                  alu_op, mem_read, mem_write, wb_sel, state, illegal_op};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic void push(input logic [5:0] op, input logic rdy, input logic zr, input outs_t o);
        cyc_t c;
        c.op  = op;
        c.rdy = rdy;
        c.zr  = zr;
        c.exp = o;
        c.cnt = m_cnt;
        q.push_back(c);
    endfunction

    // Expand one instruction into the cycle-by-cycle trace the control unit must produce.
    // fw/mw = wait cycles before mem_ready in FETCH/MEM; z = ALU zero flag seen in EXEC.
    function automatic void build(input int op, input int fw, input int mw, input logic z);
        outs_t      o;
        logic [5:0] opc;
        logic       taken;
        opc = 6'(op);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.st = 3'(S_FETCH); o.mr = 1'b1;
            push(opc, 1'b0, rnd(), o);
        end
        o = '0; o.st = 3'(S_FETCH); o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
        push(opc, 1'b1, rnd(), o);

        o = '0; o.st = 3'(S_DECODE);
        if (op == 9) begin
            o.pcw = 1'b1; o.pcs = 2'd2;
            push(opc, rnd(), rnd(), o);
            m_cnt++;
            return;
        end
        if (op > 10) begin
            o.ill = 1'b1;
            push(opc, rnd(), rnd(), o);
            return;
        end
        push(opc, rnd(), rnd(), o);

        if (op == 10) begin
            o = '0; o.st = 3'(S_WB); o.rw = 1'b1; o.rds = 1'b1; o.wbs = 2'd2;
            o.pcw = 1'b1; o.pcs = 2'd2;
            push(opc, rnd(), rnd(), o);
            m_cnt++;
            return;
        end

        o = '0; o.st = 3'(S_EXEC);
        case (op)
            0, 1, 2: o.aop = 3'(op);
            3, 5, 6: begin o.asb = 1'b1; o.aop = 3'd0; end
            4:       begin o.asb = 1'b1; o.aop = 3'd2; end
            default: begin
                o.aop = 3'd1;
                taken = (op == 7) ? z : !z;
                o.pcw = taken;
                o.pcs = taken ? 2'd1 : 2'd0;
            end
        endcase
        push(opc, rnd(), z, o);
        if (op == 7 || op == 8) begin
            m_cnt++;
            return;
        end

        if (op == 5 || op == 6) begin
            o = '0; o.st = 3'(S_MEM);
            if (op == 5) o.mr = 1'b1; else o.mw = 1'b1;
            for (int i = 0; i < mw; i++) push(opc, 1'b0, rnd(), o);
            push(opc, 1'b1, rnd(), o);
            if (op == 6) begin
                m_cnt++;
                return;
            end
        end

        o = '0; o.st = 3'(S_WB); o.rw = 1'b1; o.wbs = (op == 5) ? 2'd1 : 2'd0;
        push(opc, rnd(), rnd(), o);
        m_cnt++;
    endfunction

    // Replay up to n trace cycles; entered and left just after a rising edge.
    task automatic run_n(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            opcode    = c.op;
            mem_ready = c.rdy;
            zero      = c.zr;
            @(negedge clk);
            chk($sformatf("outs_op%0d_st%0d", c.op, c.exp.st), obs, c.exp);
            chk($sformatf("count_op%0d", c.op), instr_count, c.cnt);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk(tag, obs, '0);
        chk({tag, "_count"}, instr_count, m_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int op;
        rst_n     = 1'b1;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        m_cnt     = '0;
        #2 rst_n  = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", obs, '0);
            chk("reset_count", instr_count, 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("idle_after_release");

        // Directed pass over every instruction class and the branch polarities.
        build(0, 0, 0, 1'b0);
        build(5, 0, 3, 1'b0);
        build(6, 1, 2, 1'b0);
        build(7, 0, 0, 1'b1);
        build(7, 0, 0, 1'b0);
        build(8, 0, 0, 1'b1);
        build(8, 0, 0, 1'b0);
        build(10, 0, 0, 1'b0);
        build(9, 0, 0, 1'b0);
        build(63, 0, 0, 1'b0);
        build(3, 2, 0, 1'b0);
        build(4, 0, 0, 1'b1);
        build(1, 0, 0, 1'b0);
        build(2, 1, 0, 1'b0);
        run_n(q.size());

        // Random instruction stream with random memory latency.
        repeat (250) begin
            op = int'($urandom_range(0, 13));
            if (op > 10) op = int'($urandom_range(11, 63));
            build(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rnd());
            run_n(q.size());
        end

        // Reset in the middle of a store's memory wait.
        build(6, 0, 3, 1'b0);
        run_n(4);
        mem_ready = 1'b0;
        #1;
        chk("sw_wait_mem_write", mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", obs, '0);
        chk("midrst_count", instr_count, 32'd0);
        q.delete();
        m_cnt = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("idle_after_midrst");
        build(0, 0, 0, 1'b0);
        build(6, 0, 1, 1'b0);
        run_n(q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle control FSM for the 32-bit RISC core. Sequences FETCH/DECODE/EXEC/MEM/WB and drives the register file write port (reg_write, destination select) and the write-back mux. It also drives PC/IR enables, ALU control and memory strobes, and waits on a memory ready handshake. It sits directly upstream of register_file and the datapath muxes, and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
RA_REG, 31, register index written by JAL (return address)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until the next FETCH completes
zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC load enable
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
ir_write  out  1  IR load enable
reg_write  out  1  register file write enable
reg_dst_sel  out  1  0=rd field IR[25:21], 1=RA_REG
alu_src_b  out  1  0=rs2 data, 1=sign-extended imm16
alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=PASS_A
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
wb_sel  out  2  0=ALU result, 1=memory data, 2=PC (already PC+4)
state  out  3  current FSM state, for debug
illegal_op  out  1  one-cycle pulse on an undefined opcode
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: async on rst_n low. state=IDLE, instr_count=0. All outputs 0 while rst_n low and while in IDLE.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- Opcodes: 0 ADD, 1 SUB, 2 AND (R-type); 3 ADDI, 4 ANDI; 5 LW; 6 SW; 7 BEQ; 8 BNE; 9 J; 10 JAL; 11-63 illegal.
- Outputs are combinational from (state, opcode, zero, mem_ready). Only state and instr_count are registered.
- FETCH: mem_read=1. Hold while mem_ready=0. On the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
- DECODE:
  - J: pc_write=1, pc_src=2, retire, next FETCH.
  - JAL: next WB.
  - Illegal: illegal_op=1, no retire, next FETCH.
  - All other opcodes: next EXEC.
- EXEC:
  - R-type: alu_src_b=0, alu_op per opcode, next WB.
  - ADDI/ANDI/LW/SW: alu_src_b=1, ADD or AND, next WB (ALU immediate ops) or MEM (LW/SW).
  - BEQ/BNE: alu_op=SUB, alu_src_b=0. pc_write=1, pc_src=1 iff (BEQ and zero) or (BNE and !zero). Retire, next FETCH.
- MEM:
  - LW: mem_read=1, wait on mem_ready, then next WB.
  - SW: mem_write=1, wait on mem_ready, then retire and next FETCH.
  - Strobes stay high every wait cycle. No timeout.
- WB: reg_write=1 for exactly one cycle, retire, next FETCH.
  - ALU ops: wb_sel=0, reg_dst_sel=0.
  - LW: wb_sel=1, reg_dst_sel=0.
  - JAL: wb_sel=2, reg_dst_sel=1, plus pc_write=1, pc_src=2 in the same cycle.
- Retire: instr_count increments by 1 on the transition into FETCH for retired instructions; wraps modulo 2^CNT_W.
- Invariants: reg_write, mem_write and mem_read are never both-asserted combinations. reg_write is never high outside WB.
- Reset mid-operation (e.g. during a MEM wait): outputs drop immediately, state=IDLE; no partial write is issued after release.
- Unused encodings of state force next state FETCH.

Decomposition:
- Package mc_ctrl_pkg: state encoding (IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5), opcode constants, alu_op, pc_src and wb_sel encodings.
- Sub-module mc_ctrl_decode: combinational opcode -> class (rtype, itype, load, store, branch, jump, jal, illegal) plus alu_op.
- The top holds the FSM and the counter.

Test Plan:
1. Reset hold and release: rst_n low 3 cycles with mem_ready=1 -> all outputs 0, state=0. After release: IDLE for 1 cycle, then FETCH with mem_read=1.
2. ADD (opcode 0), mem_ready=1 immediately: FETCH, DECODE, EXEC (alu_op=0, alu_src_b=0), WB (reg_write=1, wb_sel=0, reg_dst_sel=0). 4 cycles total, instr_count 0->1. Paired with register_file: rd=5 reads back the written value.
3. LW (5) with mem_ready low 3 cycles in MEM: mem_read held 4 cycles. WB has wb_sel=1, reg_write=1. SW (6): mem_write=1 in MEM, reg_write never 1.
4. BEQ (7): zero=1 -> pc_write=1, pc_src=1 in EXEC. zero=0 -> pc_write=0. BNE (8) gives the inverse. Both increment instr_count.
5. JAL (10): DECODE then WB with reg_write=1, reg_dst_sel=1, wb_sel=2, pc_write=1, pc_src=2. J (9): pc_src=2 in DECODE, no reg_write.
6. Opcode 63: illegal_op pulse 1 cycle in DECODE, instr_count unchanged. Then assert rst_n=0 mid-MEM of an SW -> mem_write drops the same cycle, state=0.
